// File: rtl/sram_write_checker.sv
// sram_write_checker: audits snooped SRAM writes against an expected-data ROM and checks that a region is fully covered
// Ports: Clock_50 / Reset (synchronous, active-high); Start and Finish are single-cycle control pulses;
//   SRAM_address / SRAM_write_data / SRAM_we_n form the snooped bus; Exp_address / Exp_data form the ROM lookup
//   (1-cycle read latency); four saturating error counters; First_err_address / First_err_valid capture the first error;
//   Busy / Done / Pass / Late_write report status.
module sram_write_checker #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int REGION_BASE = 0,
  parameter int REGION_SIZE = 76800,
  parameter int CNT_W       = 16
) (
  input  logic              Clock_50,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Finish,
  input  logic [ADDR_W-1:0] SRAM_address,
  input  logic [DATA_W-1:0] SRAM_write_data,
  input  logic              SRAM_we_n,
  output logic [ADDR_W-1:0] Exp_address,
  input  logic [DATA_W-1:0] Exp_data,
  output logic [CNT_W-1:0]  Mismatch_count,
  output logic [CNT_W-1:0]  Out_of_region_count,
  output logic [CNT_W-1:0]  Multi_write_count,
  output logic [CNT_W-1:0]  Unwritten_count,
  output logic [ADDR_W-1:0] First_err_address,
  output logic              First_err_valid,
  output logic              Busy,
  output logic              Done,
  output logic              Pass,
  output logic              Late_write
);
  localparam int IW = REGION_SIZE > 1 ? $clog2(REGION_SIZE) : 1;
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_SWEEP, S_DONE} state_t;
  state_t                 state;
  logic [REGION_SIZE-1:0] bitmap;
  logic [ADDR_W:0]        off;
  logic [IW-1:0]          idx;
  logic [IW-1:0]          sweep_idx;
  logic                   sweep_last;
  logic                   in_region;
  logic                   wr;
  logic                   oor;
  logic                   multi;
  logic                   mism;
  logic                   p_valid;
  logic [ADDR_W-1:0]      p_addr;
  logic [DATA_W-1:0]      p_data;
  logic                   u_valid;
  logic [ADDR_W-1:0]      u_addr;
  logic [ADDR_W-1:0]      err_addr;

  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] c, input logic e);
    return c + CNT_W'(e && c != '1);
  endfunction

  assign Exp_address = SRAM_address;
  // One extra bit keeps the offset sign: addresses below the base come out negative.
  assign off       = {1'b0, SRAM_address} - (ADDR_W+1)'(REGION_BASE);
  assign in_region = !off[ADDR_W] && off < (ADDR_W+1)'(REGION_SIZE);
  assign idx       = off[IW-1:0];
  assign wr        = !SRAM_we_n && state == S_ARMED;
  assign oor       = wr && !in_region;
  assign multi     = wr && in_region && bitmap[idx];
  assign mism      = p_valid && Exp_data != p_data;
  // The pending compare belongs to an older write, so it wins the first-error race.
  assign err_addr  = mism ? p_addr : (oor || multi) ? SRAM_address : u_addr;
  assign Busy      = state == S_ARMED || state == S_SWEEP;
  assign Done      = state == S_DONE;
  assign Pass      = Done && !Late_write && Mismatch_count == '0 && Out_of_region_count == '0 &&
                     Multi_write_count == '0 && Unwritten_count == '0;

  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      state               <= S_IDLE;
      bitmap              <= '0;
      Mismatch_count      <= '0;
      Out_of_region_count <= '0;
      Multi_write_count   <= '0;
      Unwritten_count     <= '0;
      First_err_address   <= '0;
      First_err_valid     <= 1'b0;
      Late_write          <= 1'b0;
      p_valid             <= 1'b0;
      p_addr              <= '0;
      p_data              <= '0;
      u_valid             <= 1'b0;
      u_addr              <= '0;
      sweep_idx           <= '0;
      sweep_last          <= 1'b0;
    end else if (Start) begin
      state               <= S_ARMED;
      bitmap              <= '0;
      Mismatch_count      <= '0;
      Out_of_region_count <= '0;
      Multi_write_count   <= '0;
      Unwritten_count     <= '0;
      First_err_valid     <= 1'b0;
      Late_write          <= 1'b0;
      p_valid             <= 1'b0;
      u_valid             <= 1'b0;
    end else begin
      p_valid             <= wr && in_region;
      p_addr              <= SRAM_address;
      p_data              <= SRAM_write_data;
      if (wr && in_region) bitmap[idx] <= 1'b1;
      Mismatch_count      <= sat(Mismatch_count, mism);
      Out_of_region_count <= sat(Out_of_region_count, oor);
      Multi_write_count   <= sat(Multi_write_count, multi);
      Unwritten_count     <= sat(Unwritten_count, u_valid);
      if (!First_err_valid && (mism || oor || multi || u_valid)) begin
        First_err_address <= err_addr;
        First_err_valid   <= 1'b1;
      end
      if (!SRAM_we_n && (state == S_SWEEP || state == S_DONE)) Late_write <= 1'b1;
      // Sweep result is registered and counted a cycle later, hence the extra drain cycle.
      u_valid             <= state == S_SWEEP && !sweep_last && !bitmap[sweep_idx];
      u_addr              <= ADDR_W'(REGION_BASE) + ADDR_W'(sweep_idx);
      if (state == S_ARMED && Finish) begin
        state      <= S_SWEEP;
        sweep_idx  <= '0;
        sweep_last <= 1'b0;
      end else if (state == S_SWEEP) begin
        sweep_idx  <= sweep_idx + IW'(1);
        sweep_last <= sweep_idx == IW'(REGION_SIZE - 1);
        if (sweep_last) state <= S_DONE;
      end
    end
  end
endmodule

// File: tb/tb_sram_write_checker.sv
// tb_sram_write_checker: directed scenarios for sram_write_checker with a queue-based scoreboard
module tb_sram_write_checker;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int RS = 8;
  localparam int CW = 2;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          finish = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic          we_n = 1'b1;
  logic [AW-1:0] exp_address;
  logic [DW-1:0] exp_data = '0;
  logic [CW-1:0] mism_cnt, oor_cnt, multi_cnt, unw_cnt;
  logic [AW-1:0] fea;
  logic          fev, busy, done, pass, late;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            fin_cyc = 0;
  int            wait_cnt = 0;
  logic          done_d = 1'b0;

  typedef struct {
    string name;
    bit    kind;
    bit    busy, done, pass;
    int    mism, oor, multi, unw;
    bit    fev;
    int    fea;
    bit    late;
  } exp_t;
  exp_t q[$];

  sram_write_checker #(.ADDR_W(AW), .DATA_W(DW), .REGION_BASE(0), .REGION_SIZE(RS), .CNT_W(CW)) dut (
    .Clock_50(clk), .Reset(rst), .Start(start), .Finish(finish),
    .SRAM_address(addr), .SRAM_write_data(wdata), .SRAM_we_n(we_n),
    .Exp_address(exp_address), .Exp_data(exp_data),
    .Mismatch_count(mism_cnt), .Out_of_region_count(oor_cnt),
    .Multi_write_count(multi_cnt), .Unwritten_count(unw_cnt),
    .First_err_address(fea), .First_err_valid(fev),
    .Busy(busy), .Done(done), .Pass(pass), .Late_write(late)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    return 16'h1232 + DW'(a);
  endfunction

  always @(posedge clk) begin
    exp_data <= rom_f(exp_address);
    cyc      <= cyc + 1;
  end

  task automatic cmp(input string n, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", n, act, want);
    end
  endtask

  task automatic cmp_all(input exp_t e);
    cmp({e.name, ".busy"}, int'(busy), int'(e.busy));
    cmp({e.name, ".done"}, int'(done), int'(e.done));
    cmp({e.name, ".pass"}, int'(pass), int'(e.pass));
    cmp({e.name, ".mismatch"}, int'(mism_cnt), e.mism);
    cmp({e.name, ".out_of_region"}, int'(oor_cnt), e.oor);
    cmp({e.name, ".multi_write"}, int'(multi_cnt), e.multi);
    cmp({e.name, ".unwritten"}, int'(unw_cnt), e.unw);
    cmp({e.name, ".first_err_valid"}, int'(fev), int'(e.fev));
    cmp({e.name, ".first_err_address"}, int'(fea), e.fea);
    cmp({e.name, ".late_write"}, int'(late), int'(e.late));
  endtask

  // Monitor: snapshots are checked at the next falling edge, results on the rising edge of Done.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      if (!q[0].kind) begin
        cmp_all(q[0]);
        void'(q.pop_front());
      end else if (done && !done_d) begin
        cmp_all(q[0]);
        cmp({q[0].name, ".latency"}, cyc - fin_cyc, RS + 2);
        void'(q.pop_front());
        wait_cnt = 0;
      end else if (wait_cnt > 60) begin
        cmp({q[0].name, ".done_timeout"}, 0, 1);
        void'(q.pop_front());
        wait_cnt = 0;
      end else wait_cnt++;
    end
    if (finish && !start && !rst) fin_cyc = cyc;
    done_d = done;
  end

  task automatic push(input string n, input bit k, input bit b, input bit d, input bit p, input int mi,
                      input int oo, input int mu, input int un, input bit fv, input int fa, input bit lt);
    exp_t e;
    e.name = n; e.kind = k; e.busy = b; e.done = d; e.pass = p; e.mism = mi; e.oor = oo;
    e.multi = mu; e.unw = un; e.fev = fv; e.fea = fa; e.late = lt;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    addr = AW'(a); wdata = d; we_n = 1'b0;
    tick();
    we_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_finish();
    finish = 1'b1;
    tick();
    finish = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    push("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    drain();
    pulse_start();
    push("armed", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int a = 0; a < RS; a++) wr(a, rom_f(AW'(a)));
    push("clean", 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    pulse_finish();
    drain();
    pulse_start();
    for (int a = 0; a < RS; a++) wr(a, a == 3 ? 16'h1234 : rom_f(AW'(a)));
    push("mismatch", 1, 0, 1, 0, 1, 0, 0, 0, 1, 3, 0);
    pulse_finish();
    drain();
    pulse_start();
    for (int a = 0; a < 5; a++) wr(a, rom_f(AW'(a)));
    wr(5, rom_f(5)); wr(5, rom_f(5)); wr(8, 16'h0000); wr(6, rom_f(6)); wr(7, rom_f(7));
    push("multi", 1, 0, 1, 0, 0, 1, 1, 0, 1, 5, 0);
    pulse_finish();
    drain();
    pulse_start();
    for (int a = 0; a < 6; a++) wr(a, rom_f(AW'(a)));
    push("unwritten", 1, 0, 1, 0, 0, 0, 0, 2, 1, 6, 0);
    pulse_finish();
    drain();
    pulse_start();
    wr(8, 16'h1); wr(9, 16'h2); wr(200, 16'h3); wr(255, 16'h4); wr(100, 16'h5);
    for (int a = 0; a < 7; a++) wr(a, rom_f(AW'(a)));
    push("saturate", 1, 0, 1, 0, 1, 3, 0, 0, 1, 8, 1);
    addr = 7; wdata = 16'hbeef; we_n = 1'b0;
    pulse_finish();
    we_n = 1'b1;
    tick(); tick();
    wr(0, rom_f(0));
    drain();
    pulse_start();
    for (int a = 0; a < RS; a++) wr(a, a == 7 ? 16'h0bad : rom_f(AW'(a)));
    pulse_finish();
    tick();
    rst = 1'b1;
    tick();
    push("mid_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    push("after_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drain();
    pulse_start();
    for (int a = 0; a < RS; a++) wr(a, rom_f(AW'(a)));
    push("rerun", 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    pulse_finish();
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
